// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: owns the fetch PC, drives the imem request handshake and buffers pairs.
// Define FETCH_PERF_EN to add saturating stall/redirect performance counters.
module fetch_sequencer #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [PC_W-1:0] target_in,
  output logic            ir_valid,
  output logic [15:0]     p0_IR,
  output logic [15:0]     p1_IR,
  output logic [PC_W-1:0] pc_out,
  output logic            ir0_invalid,
  output logic            fetch_next,
  output logic            flush_s1
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_redirect_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  drain_addr;
  logic             kill_p0;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  logic [PC_W-1:0]  buf_pc   [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic             buf_kill [DEPTH];

  assign mem_req    = (state == REQ) || (state == DRAIN);
  assign mem_addr   = (state == DRAIN) ? drain_addr : fetch_pc;
  assign ir_valid   = (count != '0);
  assign fetch_next = ir_valid && !stall_in && !redirect_in;
  assign pop        = fetch_next;
  // An ack in DRAIN belongs to the pre-redirect request, so only REQ pushes.
  assign push       = (state == REQ) && mem_ack && !redirect_in && ((count != FULL) || pop);
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  assign p0_IR       = ir_valid ? buf_data[rd_ptr][15:0]  : '0;
  assign p1_IR       = ir_valid ? buf_data[rd_ptr][31:16] : '0;
  assign pc_out      = ir_valid ? buf_pc[rd_ptr] : '0;
  assign ir0_invalid = ir_valid && buf_kill[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= fetch_pc;
      buf_data[wr_ptr] <= mem_rdata;
      buf_kill[wr_ptr] <= kill_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      kill_p0    <= 1'b0;
      flush_s1   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      flush_s1 <= redirect_in;
      if (redirect_in) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        fetch_pc <= {target_in[PC_W-1:1], 1'b0};
        kill_p0  <= target_in[0];
        // Keep an unacked request alive at its old address until memory accepts it.
        if (mem_req && !mem_ack) begin
          state      <= DRAIN;
          drain_addr <= mem_addr;
        end else begin
          state <= REQ;
        end
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_nxt;
        case (state)
          BOOT: state <= REQ;
          REQ: begin
            if (push) begin
              fetch_pc <= fetch_pc + PC_W'(2);
              kill_p0  <= 1'b0;
              state    <= (count_nxt == FULL) ? HOLD : REQ;
            end
          end
          HOLD: begin
            if (pop) state <= REQ;
          end
          DRAIN: begin
            if (mem_ack) state <= REQ;
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (ir_valid && stall_in && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (redirect_in && (perf_redirect_cnt != 16'hFFFF))
        perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
